seq_pattern_tx: RTL and testbench
=================================

Name: seq_pattern_tx

Overview:
Serial pattern transmitter: the transmit end of the single-bit serial stream `x` that the sequence-detector FSMs consume. It loads a parallel pattern word and shifts it out one bit per clock, MSB of the active field first. The pattern can be repeated, with optional idle gap cycles between repetitions. It is the on-chip stimulus source for the detector FSMs and drives their `x` input directly.

Parameters:
- W, 16, maximum pattern length in bits.
- LW, $clog2(W+1), width of the `len` port.
- RW, 4, width of the `reps` port.
- GAP, 0, idle cycles inserted between repetitions (0 = back-to-back).
- IDLE_LEVEL, 1'b0, value driven on `x` whenever no pattern bit is being sent.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- reset_n, input, 1, synchronous active-low reset.
- start, input, 1, request transmission; sampled only in IDLE.
- data_in, input, W, pattern word; active field is data_in[len-1:0].
- len, input, LW, pattern length, 1..W.
- reps, input, RW, additional repetitions; total transmissions = reps+1.
- x, output, 1, serial bit out (registered).
- x_valid, output, 1, high when `x` carries a pattern bit.
- busy, output, 1, high in SHIFT and GAP.
- done, output, 1, one-cycle pulse after the final bit.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - state=IDLE; x=IDLE_LEVEL; x_valid=0; busy=0; done=0; internal counters cleared.
  - Reset takes priority over everything and aborts any transfer mid-pattern, with no done pulse.
- State machine: IDLE, SHIFT, GAP, DONE. All outputs are registered.
- IDLE:
  - If start=1 and 1<=len<=W: capture data_in, len and reps into shadow registers; go to SHIFT.
  - If start=1 and len=0 or len>W: the request is ignored and the state stays IDLE.
  - Later changes to data_in, len or reps have no effect on the transfer in progress.
- SHIFT:
  - The first pattern bit appears on `x` with x_valid=1 in the cycle after the accepting edge (1-cycle latency).
  - Bit order: data[len-1] down to data[0], one bit per cycle, so each pass spans exactly `len` cycles.
  - After bit 0: if repetitions remain and GAP>0, go to GAP; if repetitions remain and GAP=0, restart at data[len-1] on the very next cycle with no bubble; if none remain, go to DONE.
- GAP:
  - Lasts exactly GAP cycles with x=IDLE_LEVEL, x_valid=0, busy=1.
  - Then returns to SHIFT at data[len-1].
- DONE:
  - Lasts one cycle with done=1, busy=0, x_valid=0, x=IDLE_LEVEL; then IDLE.
  - start in DONE is ignored, so the earliest restart is in the next IDLE cycle.
- start while busy or in DONE is ignored, with no queuing.
- Cycles per transfer from acceptance to the done pulse: (reps+1)*len + reps*GAP, followed by the 1 done cycle.
- len=1 is legal and sends a single bit per pass.
- reps = 2^RW-1 gives 2^RW passes; the repetition counter must not wrap early.
- x_valid and busy never glitch between back-to-back passes when GAP=0.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles mid-transfer (after 5 of 15 bits), then release -> x=0, x_valid=0, busy=0, done=0 on the next edge; no done pulse; next start is accepted normally.
- Basic pattern: data_in=16'h582F with len=15 (field 101100000101111) and reps=0 -> x_valid high for exactly 15 cycles; `x` emits 1,0,1,1,0,0,0,0,0,1,0,1,1,1,1 starting one cycle after start; done pulses once, 1 cycle after the last bit.
- Detector stimulus: data_in=15'b101100000111110, len=15, reps=0, output wired to the consecutive-sequence detector -> the bit stream matches the detector bench's serial stimulus exactly, bit for bit.
- Repeat with gap: GAP=2, data_in=4'b1101, len=4, reps=2 -> stream 1101,--,1101,--,1101, where -- is x=0 with x_valid=0; busy high for 16 cycles; done at cycle 17.
- Repeat without gap: GAP=0, data_in=3'b100, len=3, reps=1 -> 100100 contiguous; x_valid stays high for 6 cycles.
- Illegal and busy starts:
  - len=0 with start=1 -> busy stays 0 and no output.
  - start pulsed mid-transfer with a different data_in -> ignored; the original pattern completes unchanged.
  - start asserted during the done cycle -> ignored.
  - start asserted the cycle after done -> accepted.

Source files
------------

// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// seq_pattern_tx : serial pattern transmitter, MSB-first with optional
//                  repetition and idle gap cycles between passes.
// Revision       : 1.0
// ============================================================================
module seq_pattern_tx #(
    parameter int   W          = 16,
    parameter int   LW         = $clog2(W + 1),
    parameter int   RW         = 4,
    parameter int   GAP        = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [W-1:0]  data_in,
    input  logic [LW-1:0] len,
    input  logic [RW-1:0] reps,
    output logic          x,
    output logic          x_valid,
    output logic          busy,
    output logic          done
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [LW-1:0] c_len_max  = LW'(W);
    localparam logic [GW-1:0] c_gap_last = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q;
    logic [W-1:0]  data_q;
    logic [IW-1:0] top_q;
    logic [IW-1:0] idx_q;
    logic [RW-1:0] reps_q;
    logic [GW-1:0] gap_q;
    logic          x_q;
    logic          x_valid_q;
    logic          busy_q;
    logic          done_q;

    logic          w_len_ok;
    logic [IW-1:0] w_in_top;

    assign w_len_ok = (len != '0) && (len <= c_len_max);
    // len is known to be 1..W when this is used, so the truncation is lossless
    assign w_in_top = IW'(len - 1'b1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            top_q     <= '0;
            idx_q     <= '0;
            reps_q    <= '0;
            gap_q     <= '0;
            x_q       <= IDLE_LEVEL;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && w_len_ok) begin
                        data_q    <= data_in;
                        top_q     <= w_in_top;
                        idx_q     <= w_in_top;
                        reps_q    <= reps;
                        x_q       <= data_in[w_in_top];
                        x_valid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (idx_q != '0) begin
                        idx_q <= idx_q - 1'b1;
                        x_q   <= data_q[idx_q - 1'b1];
                    end else if (reps_q != '0) begin
                        reps_q <= reps_q - 1'b1;
                        if (GAP > 0) begin
                            gap_q     <= c_gap_last;
                            x_q       <= IDLE_LEVEL;
                            x_valid_q <= 1'b0;
                            state_q   <= S_GAP;
                        end else begin
                            // back-to-back restart keeps x_valid/busy solid
                            idx_q <= top_q;
                            x_q   <= data_q[top_q];
                        end
                    end else begin
                        x_q       <= IDLE_LEVEL;
                        x_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_GAP: begin
                    if (gap_q != '0) begin
                        gap_q <= gap_q - 1'b1;
                    end else begin
                        idx_q     <= top_q;
                        x_q       <= data_q[top_q];
                        x_valid_q <= 1'b1;
                        state_q   <= S_SHIFT;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// tb_seq_pattern_tx : checks two transmitter instances (GAP=0 and GAP=2)
//                     against a timeline model and literal expectations.
// Revision          : 1.0
// ============================================================================
module tb_seq_pattern_tx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_a;
    logic        start_b;
    logic [15:0] data_in;
    logic [4:0]  len;
    logic [3:0]  reps;
    logic        xa, va, ba, da;
    logic        xb, vb, bb, db;

    always #5 clk = ~clk;

    seq_pattern_tx #(.W(16), .RW(4), .GAP(0), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .data_in(data_in),
        .len(len), .reps(reps), .x(xa), .x_valid(va), .busy(ba), .done(da)
    );

    seq_pattern_tx #(.W(16), .RW(4), .GAP(2), .IDLE_LEVEL(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .data_in(data_in),
        .len(len), .reps(reps), .x(xb), .x_valid(vb), .busy(bb), .done(db)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Expected {x, x_valid, busy, done} at cycle t after the accepting edge
    function automatic logic [3:0] expect_at(input logic [15:0] d, input int l,
                                             input int r, input int g, input int t);
        int total;
        int pos;
        total = (r + 1) * l + r * g;
        if (t < total) begin
            pos = t % (l + g);
            if (pos < l) return {d[l-1-pos], 1'b1, 1'b1, 1'b0};
            return 4'b0010;
        end
        if (t == total) return 4'b0001;
        return 4'b0000;
    endfunction

    logic [3:0]  exp_o [2];
    bit          act_m [2];
    int          t_m   [2];
    logic [15:0] d_m   [2];
    int          l_m   [2];
    int          r_m   [2];
    int          gap_m [2];
    bit          chk_en = 1'b0;

    initial begin
        gap_m[0] = 0;
        gap_m[1] = 2;
        for (int i = 0; i < 2; i++) begin
            exp_o[i] = 4'b0000;
            act_m[i] = 1'b0;
            t_m[i]   = 0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                logic s;
                s = (i == 0) ? start_a : start_b;
                if (!reset_n) begin
                    act_m[i] = 1'b0;
                    exp_o[i] = 4'b0000;
                end else if (act_m[i]) begin
                    t_m[i]++;
                    if (t_m[i] > (r_m[i] + 1) * l_m[i] + r_m[i] * gap_m[i]) begin
                        act_m[i] = 1'b0;
                        exp_o[i] = 4'b0000;
                    end else begin
                        exp_o[i] = expect_at(d_m[i], l_m[i], r_m[i], gap_m[i], t_m[i]);
                    end
                end else if (s && len >= 1 && len <= 16) begin
                    d_m[i]   = data_in;
                    l_m[i]   = int'(len);
                    r_m[i]   = int'(reps);
                    t_m[i]   = 0;
                    act_m[i] = 1'b1;
                    exp_o[i] = expect_at(d_m[i], l_m[i], r_m[i], gap_m[i], 0);
                end else begin
                    exp_o[i] = 4'b0000;
                end
            end
        end
    end

    // Per-cycle comparison plus observed-stream statistics
    logic [63:0] cap_a, cap_b;
    int nv_a, nv_b, nd_a, nd_b, nb_a, nb_b, run_a, maxrun_a;

    task automatic clear_stats();
        cap_a = '0; cap_b = '0;
        nv_a = 0; nv_b = 0; nd_a = 0; nd_b = 0; nb_a = 0; nb_b = 0;
        run_a = 0; maxrun_a = 0;
    endtask

    initial begin
        clear_stats();
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("cycle_a", {xa, va, ba, da}, exp_o[0]);
                check("cycle_b", {xb, vb, bb, db}, exp_o[1]);
                if (va) begin
                    cap_a = {cap_a[62:0], xa};
                    nv_a++;
                    run_a++;
                    if (run_a > maxrun_a) maxrun_a = run_a;
                end else begin
                    run_a = 0;
                end
                if (vb) begin
                    cap_b = {cap_b[62:0], xb};
                    nv_b++;
                end
                if (da) nd_a++;
                if (db) nd_b++;
                if (ba) nb_a++;
                if (bb) nb_b++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_start(input int inst, input logic v);
        if (inst == 0) start_a = v;
        else start_b = v;
    endtask

    task automatic wait_done(input int inst, inout int k);
        while (((inst == 0) ? da : db) !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) begin
            n_checks++;
            $display("FAIL done_timeout: inst %0d got no done after %0d cycles, expected one", inst, k);
        end
    endtask

    // Pulse start for one edge; k counts cycles from acceptance to the done pulse
    task automatic xfer(input int inst, input logic [15:0] d, input logic [4:0] l,
                        input logic [3:0] r, output int k, output logic [1:0] first);
        data_in = d;
        len     = l;
        reps    = r;
        set_start(inst, 1'b1);
        tick();
        set_start(inst, 1'b0);
        first = (inst == 0) ? {xa, va} : {xb, vb};
        k = 1;
        wait_done(inst, k);
    endtask

    int         k;
    logic [1:0] first;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        data_in = '0;
        len     = '0;
        reps    = '0;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        tick();
        reset_n = 1'b1;
        check("reset_a", {xa, va, ba, da}, 4'b0000);
        check("reset_b", {xb, vb, bb, db}, 4'b0000);

        // Basic 15-bit pattern
        clear_stats();
        xfer(0, 16'h582F, 5'd15, 4'd0, k, first);
        check("basic_first_bit", first, 2'b11);
        check("basic_cycles", k, 16);
        check("basic_stream", cap_a[14:0], 15'b101100000101111);
        check("basic_nvalid", nv_a, 15);
        check("basic_ndone", nd_a, 1);
        tick();

        // Detector stimulus stream
        clear_stats();
        xfer(0, 16'b0101100000111110, 5'd15, 4'd0, k, first);
        check("det_stream", cap_a[14:0], 15'b101100000111110);
        tick();

        // Repeat with gap
        clear_stats();
        xfer(1, 16'b1101, 5'd4, 4'd2, k, first);
        check("gap_cycles", k, 17);
        check("gap_stream", cap_b[11:0], 12'b110111011101);
        check("gap_nvalid", nv_b, 12);
        check("gap_nbusy", nb_b, 16);
        tick();

        // Repeat without gap
        clear_stats();
        xfer(0, 16'b100, 5'd3, 4'd1, k, first);
        check("nogap_cycles", k, 7);
        check("nogap_stream", cap_a[5:0], 6'b100100);
        check("nogap_run", maxrun_a, 6);
        check("nogap_nbusy", nb_a, 6);
        tick();

        // Maximum repetitions, single-bit pattern
        clear_stats();
        xfer(0, 16'h0001, 5'd1, 4'd15, k, first);
        check("maxreps_a_cycles", k, 17);
        check("maxreps_a_nvalid", nv_a, 16);
        check("maxreps_a_run", maxrun_a, 16);
        tick();
        clear_stats();
        xfer(1, 16'h0001, 5'd1, 4'd15, k, first);
        check("maxreps_b_cycles", k, 47);
        check("maxreps_b_nvalid", nv_b, 16);
        tick();

        // Illegal lengths
        clear_stats();
        data_in = 16'hFFFF; len = 5'd0; reps = 4'd0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        len = 5'd17;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        repeat (4) tick();
        check("len0_nbusy", nb_a, 0);
        check("len0_nvalid", nv_a, 0);
        check("len17_nbusy", nb_b, 0);

        // Start while busy is ignored
        clear_stats();
        data_in = 16'h582F; len = 5'd15; reps = 4'd0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (3) tick();
        data_in = 16'hFFFF; len = 5'd16;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        k = 5;
        wait_done(0, k);
        check("busy_start_stream", cap_a[14:0], 15'b101100000101111);
        check("busy_start_nvalid", nv_a, 15);
        tick();

        // Start during the done cycle is ignored
        clear_stats();
        xfer(0, 16'h0002, 5'd2, 4'd0, k, first);
        data_in = 16'hFFFF; len = 5'd4;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (4) tick();
        check("done_start_nvalid", nv_a, 2);
        check("done_start_nbusy", nb_a, 2);

        // Start in the cycle after done is accepted
        clear_stats();
        xfer(0, 16'h0002, 5'd2, 4'd0, k, first);
        tick();
        data_in = 16'h0005; len = 5'd3;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("after_done_first", {xa, va}, 2'b11);
        k = 1;
        wait_done(0, k);
        check("after_done_stream", cap_a[4:0], 5'b10101);
        tick();

        // Reset mid-transfer
        clear_stats();
        data_in = 16'h582F; len = 5'd15; reps = 4'd0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (4) tick();
        reset_n = 1'b0;
        tick();
        check("midreset_out", {xa, va, ba, da}, 4'b0000);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check("midreset_release", {xa, va, ba, da}, 4'b0000);
        check("midreset_nvalid", nv_a, 5);
        check("midreset_ndone", nd_a, 0);
        clear_stats();
        xfer(0, 16'h582F, 5'd15, 4'd0, k, first);
        check("postreset_cycles", k, 16);
        check("postreset_stream", cap_a[14:0], 15'b101100000101111);
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
